// File: rtl/checkpoint_seq_monitor.sv
// Watches a status word for an ordered list of expected codes, with per-step
// timeout and optional strict ordering; reports pass/fail/timeout and step.
module checkpoint_seq_monitor #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned TMO_W  = 24,
  parameter int unsigned STRICT = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cfg_we_i,
  input  logic [$clog2(DEPTH)-1:0]   cfg_addr_i,
  input  logic [WIDTH-1:0]           cfg_code_i,
  input  logic [$clog2(DEPTH):0]     cfg_len_i,
  input  logic [TMO_W-1:0]           timeout_i,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [WIDTH-1:0]           status_i,
  output logic                       busy_o,
  output logic                       pass_o,
  output logic                       fail_o,
  output logic                       timeout_o,
  output logic [$clog2(DEPTH):0]     step_o,
  output logic                       step_pulse_o,
  output logic [WIDTH-1:0]           last_code_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_code [DEPTH];
  logic [WIDTH-1:0]  r_status_q;
  logic [WIDTH-1:0]  r_prev_q;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic [TMO_W-1:0]  r_tmo;
  logic [SW-1:0]     r_len;
  logic              r_busy;
  logic              r_pass;
  logic              r_fail;
  logic              r_timeout;
  logic [SW-1:0]     r_step;
  logic              r_pulse;
  logic [WIDTH-1:0]  r_last;

  logic [SW-1:0]     w_len;
  logic [WIDTH-1:0]  w_code_k;
  logic              w_match;
  logic              w_last_step;
  logic              w_strict_fail;
  logic [TMO_W:0]    w_cnt_inc;
  logic              w_tmo_hit;
  logic              w_addr_ok;

  always_comb begin
    w_len = cfg_len_i;
    if (cfg_len_i > SW'(DEPTH)) w_len = SW'(DEPTH);
  end

  assign w_code_k      = r_code[r_step[AW-1:0]];
  assign w_match       = (r_status_q == w_code_k);
  assign w_last_step   = (r_step == (r_len - SW'(1)));
  assign w_strict_fail = (STRICT != 0) && (r_status_q != r_prev_q);
  // One extra bit so the compare against tmo can never alias on wrap.
  assign w_cnt_inc     = {1'b0, r_tmo_cnt} + {{TMO_W{1'b0}}, 1'b1};
  assign w_tmo_hit     = (r_tmo != '0) && (w_cnt_inc == {1'b0, r_tmo});
  assign w_addr_ok     = (int'(cfg_addr_i) < int'(DEPTH));

  // Table has no reset so configuration survives a monitor reset.
  always_ff @(posedge clk_i) begin
    if (rst_ni && cfg_we_i && (r_state == S_IDLE) && w_addr_ok)
      r_code[cfg_addr_i] <= cfg_code_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_status_q <= '0;
      r_prev_q   <= '0;
      r_tmo_cnt  <= '0;
      r_tmo      <= '0;
      r_len      <= '0;
      r_busy     <= 1'b0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
      r_timeout  <= 1'b0;
      r_step     <= '0;
      r_pulse    <= 1'b0;
      r_last     <= '0;
    end else begin
      r_status_q <= status_i;
      r_pulse    <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if ((r_state == S_DONE) && abort_i) begin
            r_state <= S_IDLE;
          end else if (start_i) begin
            r_len     <= w_len;
            r_tmo     <= timeout_i;
            r_tmo_cnt <= '0;
            r_prev_q  <= r_status_q;
            r_fail    <= 1'b0;
            r_timeout <= 1'b0;
            r_step    <= '0;
            r_last    <= '0;
            if (w_len == '0) begin
              r_pass  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_pass  <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (abort_i) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_match) begin
            r_pulse   <= 1'b1;
            r_last    <= w_code_k;
            r_prev_q  <= w_code_k;
            r_tmo_cnt <= '0;
            if (w_last_step) begin
              r_pass  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_step <= r_step + SW'(1);
            end
          end else if (w_strict_fail) begin
            r_fail  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else if (w_tmo_hit) begin
            r_fail    <= 1'b1;
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_DONE;
          end else if (r_tmo_cnt != '1) begin
            r_tmo_cnt <= w_cnt_inc[TMO_W-1:0];
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o       = r_busy;
  assign pass_o       = r_pass;
  assign fail_o       = r_fail;
  assign timeout_o    = r_timeout;
  assign step_o       = r_step;
  assign step_pulse_o = r_pulse;
  assign last_code_o  = r_last;

endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// Bench for checkpoint_seq_monitor: non-strict and strict instances share
// stimulus and are checked every cycle against a behavioural model.
module tb_checkpoint_seq_monitor;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, we, start, abort;
  logic [2:0]  addr;
  logic [15:0] code, status;
  logic [3:0]  len;
  logic [23:0] tmo;

  logic        o_busy [2];
  logic        o_pass [2];
  logic        o_fail [2];
  logic        o_tout [2];
  logic [3:0]  o_step [2];
  logic        o_pulse[2];
  logic [15:0] o_last [2];

  int total = 0;
  int bad   = 0;
  int pcnt  = 0;
  bit chk_en = 1'b0;

  checkpoint_seq_monitor #(.WIDTH(16), .DEPTH(8), .TMO_W(24), .STRICT(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .cfg_we_i(we), .cfg_addr_i(addr), .cfg_code_i(code),
    .cfg_len_i(len), .timeout_i(tmo), .start_i(start), .abort_i(abort), .status_i(status),
    .busy_o(o_busy[0]), .pass_o(o_pass[0]), .fail_o(o_fail[0]), .timeout_o(o_tout[0]),
    .step_o(o_step[0]), .step_pulse_o(o_pulse[0]), .last_code_o(o_last[0]));

  checkpoint_seq_monitor #(.WIDTH(16), .DEPTH(8), .TMO_W(24), .STRICT(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .cfg_we_i(we), .cfg_addr_i(addr), .cfg_code_i(code),
    .cfg_len_i(len), .timeout_i(tmo), .start_i(start), .abort_i(abort), .status_i(status),
    .busy_o(o_busy[1]), .pass_o(o_pass[1]), .fail_o(o_fail[1]), .timeout_o(o_tout[1]),
    .step_o(o_step[1]), .step_pulse_o(o_pulse[1]), .last_code_o(o_last[1]));

  typedef enum logic [1:0] {M_IDLE, M_RUN, M_DONE} mmode_t;
  typedef struct packed {
    mmode_t          mode;
    logic [3:0]      len;
    logic [23:0]     tmo;
    logic [23:0]     waited;
    logic [15:0]     prev;
    logic [15:0]     sq;
    logic            pass;
    logic            fail;
    logic            tout;
    logic [3:0]      step;
    logic            pulse;
    logic [15:0]     last;
    logic [7:0][15:0] tbl;
  } mstate_t;

  mstate_t m [2] = '{'0, '0};

  // One clock of the monitor's rules; sq is the status seen one cycle late.
  function automatic mstate_t model_step(mstate_t s, bit strict);
    mstate_t n = s;
    int unsigned eff_len;
    n.pulse = 1'b0;
    if (!rst_n) begin
      n.mode = M_IDLE; n.len = '0; n.tmo = '0; n.waited = '0; n.prev = '0; n.sq = '0;
      n.pass = 1'b0; n.fail = 1'b0; n.tout = 1'b0; n.step = '0; n.last = '0;
      return n;
    end
    if (we && s.mode == M_IDLE) n.tbl[addr] = code;
    n.sq = status;
    if (s.mode == M_RUN) begin
      if (abort) n.mode = M_IDLE;
      else if (s.sq == s.tbl[s.step[2:0]]) begin
        n.pulse = 1'b1; n.last = s.sq; n.prev = s.sq; n.waited = '0;
        if (int'(s.step) + 1 == int'(s.len)) begin n.pass = 1'b1; n.mode = M_DONE; end
        else n.step = s.step + 4'd1;
      end else if (strict && s.sq != s.prev) begin
        n.fail = 1'b1; n.mode = M_DONE;
      end else if (s.tmo != 0 && int'(s.waited) + 1 == int'(s.tmo)) begin
        n.fail = 1'b1; n.tout = 1'b1; n.mode = M_DONE;
      end else if (s.waited != 24'hFFFFFF) n.waited = s.waited + 24'd1;
    end else if (s.mode == M_DONE && abort) begin
      n.mode = M_IDLE;
    end else if (start) begin
      eff_len = (len > 4'd8) ? 8 : int'(len);
      n.len = 4'(eff_len); n.tmo = tmo; n.waited = '0; n.prev = s.sq;
      n.fail = 1'b0; n.tout = 1'b0; n.step = '0; n.last = '0;
      n.pass = (eff_len == 0);
      n.mode = (eff_len == 0) ? M_DONE : M_RUN;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m[0] = model_step(m[0], 1'b0);
    m[1] = model_step(m[1], 1'b1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("busy%0d", i),  32'(o_busy[i]),  32'(m[i].mode == M_RUN));
        chk($sformatf("pass%0d", i),  32'(o_pass[i]),  32'(m[i].pass));
        chk($sformatf("fail%0d", i),  32'(o_fail[i]),  32'(m[i].fail));
        chk($sformatf("tout%0d", i),  32'(o_tout[i]),  32'(m[i].tout));
        chk($sformatf("step%0d", i),  32'(o_step[i]),  32'(m[i].step));
        chk($sformatf("pulse%0d", i), 32'(o_pulse[i]), 32'(m[i].pulse));
        chk($sformatf("last%0d", i),  32'(o_last[i]),  32'(m[i].last));
        chk($sformatf("inv_pf%0d", i), 32'(o_pass[i] & o_fail[i]), 32'd0);
        chk($sformatf("inv_tf%0d", i), 32'(o_tout[i] & ~o_fail[i]), 32'd0);
      end
      if (o_pulse[0] === 1'b1) pcnt++;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] c);
    we = 1'b1; addr = a; code = c; tick(); we = 1'b0;
  endtask

  task automatic go(input logic [3:0] l, input logic [23:0] t);
    len = l; tmo = t; start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic ab();
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic wait_pulse(input string nm);
    int n = 0;
    while (o_pulse[0] !== 1'b1 && n < 20) begin tick(); n++; end
    chk(nm, 32'(o_pulse[0]), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [23:0] tvals [2];
    rst_n = 1'b0; we = 1'b0; start = 1'b0; abort = 1'b0;
    addr = '0; code = '0; len = '0; tmo = '0; status = '0;
    tick(2);
    rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_busy", 32'(o_busy[0]), 0);
    chk("rst_step", 32'(o_step[0]), 0);
    chk("rst_last", 32'(o_last[0]), 0);

    wr(3'd0, 16'hAB60); wr(3'd1, 16'hAB61);
    for (int i = 2; i < 8; i++) wr(3'(i), 16'h1000 + 16'(i));

    // basic two-step pass
    tick(2); pcnt = 0;
    go(4'd2, 24'd0);
    status = 16'hAB60; tick(10);
    status = 16'hAB61; tick();
    chk("t1_pass_early", 32'(o_pass[0]), 0);
    tick();
    chk("t1_pass", 32'(o_pass[0]), 1);
    chk("t1_pass_strict", 32'(o_pass[1]), 1);
    chk("t1_last", 32'(o_last[0]), 32'hAB61);
    chk("t1_step", 32'(o_step[0]), 1);
    chk("t1_fail", 32'(o_fail[0]), 0);
    tick();
    chk("t1_pulses", 32'(pcnt), 2);

    // timeout exactly 100 WAIT cycles after step 0 matched
    ab(); status = '0; tick(2);
    go(4'd2, 24'd100);
    status = 16'hAB60;
    wait_pulse("t2_pulse0");
    n = 0;
    while (o_fail[0] !== 1'b1 && n < 300) begin tick(); n++; end
    chk("t2_cycles", 32'(n), 100);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("t2_tout%0d", i), 32'(o_tout[i]), 1);
      chk($sformatf("t2_step%0d", i), 32'(o_step[i]), 1);
    end

    // match on WAIT cycle 100 with tmo 101 and with tmo 100 (match beats timeout)
    tvals[0] = 24'd101; tvals[1] = 24'd100;
    for (int v = 0; v < 2; v++) begin
      ab(); status = '0; tick(2);
      go(4'd2, tvals[v]);
      status = 16'hAB60;
      wait_pulse("t2b_pulse0");
      tick(98); status = 16'hAB61; tick(2);
      chk($sformatf("t2b_pass_%0d", tvals[v]), 32'(o_pass[0]), 1);
      chk($sformatf("t2b_fail_%0d", tvals[v]), 32'(o_fail[0]), 0);
    end

    // strict ordering
    ab(); status = '0; tick(2);
    go(4'd2, 24'd0);
    status = 16'hAB60; tick(3);
    status = 16'h1234; tick(3);
    chk("t3_fail_s", 32'(o_fail[1]), 1);
    chk("t3_tout_s", 32'(o_tout[1]), 0);
    chk("t3_step_s", 32'(o_step[1]), 1);
    chk("t3_busy_ns", 32'(o_busy[0]), 1);

    // len 0
    ab(); go(4'd0, 24'd0);
    chk("t4_len0_pass", 32'(o_pass[0]), 1);
    chk("t4_len0_busy", 32'(o_busy[0]), 0);

    // len 8, one code per cycle
    ab();
    for (int i = 0; i < 8; i++) wr(3'(i), 16'(i));
    status = '0; tick(2);
    go(4'd8, 24'd0);
    status = 16'd1;
    for (int j = 1; j <= 8; j++) begin
      tick();
      chk($sformatf("t4_pulse%0d", j), 32'(o_pulse[0]), 1);
      if (j <= 6) status = 16'(j + 1);
    end
    chk("t4_len8_pass", 32'(o_pass[0]), 1);
    chk("t4_len8_pass_s", 32'(o_pass[1]), 1);

    // write while busy must be ignored
    ab(); status = 16'd5; tick(2);
    go(4'd2, 24'd0); tick();
    wr(3'd0, 16'hFFFF);
    ab(); status = '0; tick(2);
    go(4'd1, 24'd0); tick(2);
    chk("t4_nowr_pass", 32'(o_pass[0]), 1);
    chk("t4_nowr_last", 32'(o_last[0]), 0);

    // abort at step 1, restart
    ab(); wr(3'd0, 16'hAB60); wr(3'd1, 16'hAB61);
    status = '0; tick(2);
    go(4'd2, 24'd0);
    status = 16'hAB60; tick(3);
    ab();
    chk("t5_abort_busy", 32'(o_busy[0]), 0);
    chk("t5_abort_step", 32'(o_step[0]), 1);
    go(4'd2, 24'd0);
    chk("t5_restart_pass", 32'(o_pass[0]), 0);
    chk("t5_restart_step", 32'(o_step[0]), 0);
    status = 16'hAB61; tick(3);
    chk("t5_restart_done", 32'(o_pass[0]), 1);

    // reset mid-WAIT, table survives
    ab(); go(4'd2, 24'd0); tick(2);
    chk("t5_busy_pre_rst", 32'(o_busy[0]), 1);
    rst_n = 1'b0; status = '0; tick();
    chk("t5_rst_busy", 32'(o_busy[0]), 0);
    chk("t5_rst_step", 32'(o_step[0]), 0);
    chk("t5_rst_last", 32'(o_last[0]), 0);
    rst_n = 1'b1; tick(2);
    go(4'd2, 24'd0);
    status = 16'hAB60; tick(3);
    status = 16'hAB61; tick(3);
    chk("t5_post_rst_pass", 32'(o_pass[0]), 1);
    chk("t5_post_rst_pass_s", 32'(o_pass[1]), 1);

    // randomized phase
    ab();
    for (int c = 0; c < 4000; c++) begin
      int r;
      we   = ($urandom_range(0, 3) == 0);
      addr = 3'($urandom_range(0, 7));
      code = 16'hC0 + 16'($urandom_range(0, 3));
      r = $urandom_range(0, 15);
      start = (r == 0);
      abort = (r == 1);
      len = 4'($urandom_range(0, 15));
      tmo = ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom_range(1, 12));
      if ($urandom_range(0, 2) == 0) status = 16'hC0 + 16'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1; we = 1'b0; start = 1'b0; abort = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/checkpoint_seq_monitor.md
Name: checkpoint_seq_monitor

Overview:
- Synthesizable on-chip successor to the bench-side checkpoint watcher. It watches a WIDTH-bit firmware status word, for example the mprj_io[31:16] checkbits or an LA bank.
- It matches a programmable ordered list of up to DEPTH expected codes, with a per-step cycle timeout and an optional strict-order mode.
- It reports pass, fail or timeout together with the step index. It sits in the user project area, is driven by LA/Wishbone config registers, and its results are readable through the LA.

Parameters:
- WIDTH, 16, width of the status word and of each expected code.
- DEPTH, 8, number of entries in the expected-code table.
- TMO_W, 24, width of the per-step timeout counter.
- STRICT, 0, when 1 an unexpected status value causes a fail.

Ports:
- clk_i  in  1  single clock
- rst_ni  in  1  synchronous active-low reset
- cfg_we_i  in  1  write enable for the code table
- cfg_addr_i  in  $clog2(DEPTH)  table write index
- cfg_code_i  in  WIDTH  code to write
- cfg_len_i  in  $clog2(DEPTH)+1  number of steps in a run (0..DEPTH)
- timeout_i  in  TMO_W  cycles allowed per step; 0 disables the timeout
- start_i  in  1  start-run pulse
- abort_i  in  1  abort the run
- status_i  in  WIDTH  monitored status word
- busy_o  out  1  run in progress
- pass_o  out  1  sticky: all steps matched
- fail_o  out  1  sticky: run failed
- timeout_o  out  1  sticky: the fail was caused by a timeout
- step_o  out  $clog2(DEPTH)+1  index of the current or failing step
- step_pulse_o  out  1  one-cycle pulse on each matched step
- last_code_o  out  WIDTH  most recently matched code

Behaviour:
- Reset (rst_ni low at a clk_i edge) sets:
  - state to IDLE;
  - all outputs to 0;
  - status_q, prev_q and tmo_cnt to 0.
- Reset does not clear the code table.
- Reset wins over every other input, including in the middle of a run.
- Code table writes:
  - when cfg_we_i=1 and state is IDLE, code[cfg_addr_i] is written on the clock edge;
  - writes while busy are ignored;
  - out-of-range cfg_addr_i is ignored.
- status_i is registered every cycle into status_q. All comparisons use status_q, which is a 1-cycle input latency.
- States: IDLE, WAIT, DONE.
- IDLE:
  - start_i=1 captures len from cfg_len_i and tmo from timeout_i.
  - It clears pass_o, fail_o, timeout_o, step_o, last_code_o and tmo_cnt.
  - It sets prev_q to status_q.
  - If len==0: go to DONE with pass_o=1 (busy_o is never asserted).
  - Otherwise: go to WAIT with busy_o=1.
  - start_i is ignored while busy_o=1.
- WAIT, with k=step_o, evaluated in priority order:
  1. abort_i=1: go to IDLE. busy_o=0; flags and step_o are unchanged.
  2. status_q==code[k] (a match):
     - step_pulse_o=1 for one cycle;
     - last_code_o and prev_q take code[k];
     - tmo_cnt is cleared;
     - if k==len-1: pass_o=1, busy_o=0, go to DONE, and step_o stays at k;
     - otherwise step_o becomes k+1.
  3. STRICT=1 and status_q!=prev_q: fail_o=1, busy_o=0, go to DONE, step_o=k.
  4. tmo!=0 and tmo_cnt+1==tmo: fail_o=1, timeout_o=1, busy_o=0, go to DONE.
  5. Otherwise tmo_cnt increments. It saturates and never wraps.
- Timing consequences of WAIT:
  - A match is seen on the edge after status_q updates, i.e. 2 edges after status_i changes.
  - A match in the same cycle as a timeout wins.
  - timeout_i=T allows exactly T WAIT cycles per step.
- DONE: flags are held. start_i starts a new run, with the same actions as in IDLE. abort_i goes to IDLE with flags kept.
- Invariants:
  - pass_o and fail_o are never both 1.
  - timeout_o=1 implies fail_o=1.
- Repeated codes:
  - Consecutive identical table entries each need a fresh cycle.
  - A held status value matches successive equal entries on successive cycles.
- cfg_len_i greater than DEPTH is clamped to DEPTH.

Test Plan:
- STRICT=0, len=2, code={AB60,AB61}, timeout=0. Drive status AB60, then 10 cycles later AB61. Expect:
  - step_pulse_o twice;
  - pass_o=1 two edges after AB61;
  - last_code_o=AB61, step_o=1, fail_o=0.
- Timeout: len=2, timeout=100, AB60 applied and AB61 never applied. Expect fail_o=1 and timeout_o=1 with step_o=1, exactly 100 WAIT cycles after step 0 matched. Then set timeout=101 and apply AB61 on WAIT cycle 100 of step 1: the match wins and pass_o=1.
- STRICT=1: status sequence 0000 -> AB60 -> 1234. Expect fail_o=1, timeout_o=0, step_o=1. With STRICT=0 the same stimulus stays busy.
- Boundaries, each run separately:
  - len=0 gives pass_o=1 one edge after start_i with no busy.
  - len=DEPTH=8 with codes 0..7 held for 1 cycle each gives 8 consecutive step_pulse_o and then pass.
  - A table write while busy leaves the table unchanged.
- Abort and reset:
  - abort_i at step 1 gives busy_o=0 and keeps step_o=1.
  - A restart then clears the flags and passes.
  - rst_ni low in the middle of WAIT clears all outputs on the next edge, and the table contents survive (verified by a following pass run).
